clock_switch_ctrl: RTL
======================

# clock_switch_ctrl

Single-clock controller that produces the `sel` input of the glitch-free clock mux. It monitors a candidate alternate clock, `mon_clk`, sampled as asynchronous data, and counts its rising edges over fixed measurement windows to decide whether that clock is alive. It then sequences a registered, hold-off-protected switch between the primary (`sel`=0) and alternate (`sel`=1) sources on software request. It sits in the always-on reference clock domain, upstream of the mux.

## Interface
- `WINDOW_LOG2`, default 8: the measurement window is 2^WINDOW_LOG2 `clk` cycles.
- `MIN_EDGES`, default 4: minimum rising edges per window for `mon_clk` to count as alive.
- `HOLDOFF`, default 16: `clk` cycles spent in each transition state. Must be ≥1.
- `clk`  in  1  reference clock. One clock only; it is not the clock being switched.
- `reset`  in  1  synchronous, active-high reset.
- `mon_clk`  in  1  alternate clock, treated as asynchronous data. It is meaningful only when its frequency is below clk/2.
- `req_alt`  in  1  level request to run on the alternate clock.
- `sel`  out  1  registered mux select: 0 = primary, 1 = alternate.
- `alt_ok`  out  1  registered; 1 when the last completed window counted at least MIN_EDGES edges.
- `switching`  out  1  high while the FSM is in TO_ALT or TO_PRI.
- `fail`  out  1  one-cycle pulse when the alternate clock is abandoned because it was lost.
- `edge_count`  out  WINDOW_LOG2  rising-edge count of the last completed window.

## Operation
- **Synchroniser:** `mon_clk` passes through ff1 → ff2, then ff3 for edge history. `rise` = ff2 & ~ff3.
- **Window counter:** `win_cnt`, WINDOW_LOG2 bits, free-running and wrapping.
- **Edge accumulator:** `acc` increments on each `rise`. WINDOW_LOG2 bits is sufficient, because at most 2^(WINDOW_LOG2-1) edges fit in one window; no saturation logic is needed.
- **Window end** (`win_cnt` = all ones), all in the same cycle:
  - `edge_count` <= `acc` + `rise`;
  - `alt_ok` <= (`acc` + `rise` ≥ MIN_EDGES);
  - `acc` <= 0.
  - An edge detected on the final cycle of a window belongs to that window.
- **FSM states:** PRIMARY, TO_ALT, ALT, TO_PRI.
  - PRIMARY (`sel`=0): go to TO_ALT when `req_alt` & `alt_ok`.
  - TO_ALT (`sel`=1, `switching`=1): load `hold_cnt`=HOLDOFF-1 on entry. Ignore all inputs. Go to ALT when `hold_cnt` reaches 0.
  - ALT (`sel`=1): go to TO_PRI on `!req_alt`. With auto-revert enabled, also go to TO_PRI on `!alt_ok`.
  - TO_PRI (`sel`=0, `switching`=1): HOLDOFF cycles with inputs ignored, then PRIMARY.
- **Simultaneous causes in ALT:** if `!req_alt` and `!alt_ok` occur in the same cycle, take one transition. Pulse `fail` only if `req_alt`=1.
- **Reset mid-operation:** from any state, the cycle after `reset` is sampled high, the FSM is in PRIMARY with all outputs at reset values.

## Timing
- **Reset values:** `sel`=0, `alt_ok`=0, `switching`=0, `fail`=0, `edge_count`=0. `win_cnt`, `acc`, `hold_cnt` and ff1–ff3 are all 0; state is PRIMARY.
- **Detection latency:** a `mon_clk` rise sampled by ff1 at edge t gives `rise`=1 during cycle t+1, after ff2 captures it.
- **First window:** the first window ends in the 2^WINDOW_LOG2-th cycle after reset deasserts. `alt_ok` cannot be 1 earlier.
- **Switch decision:** if the condition is true in cycle t, `sel` and `switching` change at edge t+1.
- **Transition length:** `switching` stays high for exactly HOLDOFF cycles.
- **`fail` timing:** `fail` is asserted in the same cycle as the ALT→TO_PRI change of `sel`.
- **Glitch-free outputs:** all outputs are register outputs with no combinational path from inputs. `sel` changes at most once per HOLDOFF+1 cycles.

## Configuration
- `CLOCK_SWITCH_CTRL_AUTO_REVERT_EN`
  - Defined: in ALT, `alt_ok`=0 forces TO_PRI and pulses `fail`.
  - Undefined: ALT is left only on `!req_alt`. `fail` is tied 0. `alt_ok` and `edge_count` are still measured and reported.

## Test plan
All scenarios use the defaults (WINDOW_LOG2=8, MIN_EDGES=4, HOLDOFF=16).
1. Reset, `mon_clk`=0, `req_alt`=1 for 2000 cycles → `edge_count`=0 at every window end, `alt_ok`=0, `sel` stays 0.
2. `mon_clk` period 20 `clk`, `req_alt`=1 → first window `edge_count`=12 or 13 and `alt_ok`=1. `sel`=1 and `switching`=1 on the next edge, then `switching` falls after 16 cycles.
3. In ALT, stop `mon_clk` → at the first window end with count <4, `alt_ok`=0. With the macro: `sel`=0 and a one-cycle `fail` on the next edge, then PRIMARY after 16 cycles. Without the macro: `sel` stays 1.
4. Drop `req_alt` 3 cycles into TO_ALT → `sel` stays 1 for the remaining 13 cycles. ALT is held for one cycle, then TO_PRI; `fail` stays 0.
5. Exactly 4 edges in a window, the last with `rise` on the final window cycle → `edge_count`=4 and `alt_ok`=1.
6. Assert `reset` for one cycle at cycle 5 of TO_ALT → the next cycle has `sel`=0, `switching`=0, `alt_ok`=0, `edge_count`=0, and `win_cnt` restarts at 0.

Source files
------------

// File: rtl/clock_switch_ctrl.sv
// Clock-select controller: measures mon_clk liveness per window and sequences a hold-off protected sel switch.
// Optional macro CLOCK_SWITCH_CTRL_AUTO_REVERT_EN: leave ALT (and pulse fail) when the alternate clock is lost.
module clock_switch_ctrl #(
    parameter int WINDOW_LOG2 = 8,
    parameter int MIN_EDGES   = 4,
    parameter int HOLDOFF     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mon_clk,
    input  logic                   req_alt,
    output logic                   sel,
    output logic                   alt_ok,
    output logic                   switching,
    output logic                   fail,
    output logic [WINDOW_LOG2-1:0] edge_count,
    output logic [1:0]             state_dbg
);

`ifdef CLOCK_SWITCH_CTRL_AUTO_REVERT_EN
    localparam bit AUTO_REVERT = 1'b1;
`else
    localparam bit AUTO_REVERT = 1'b0;
`endif

    localparam int                     HOLD_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_LOAD   = HOLD_W'(HOLDOFF - 1);
    localparam logic [WINDOW_LOG2-1:0] MIN_EDGES_W = WINDOW_LOG2'(MIN_EDGES);

    typedef enum logic [1:0] {
        PRIMARY = 2'd0,
        TO_ALT  = 2'd1,
        ALT     = 2'd2,
        TO_PRI  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [HOLD_W-1:0]      hold_q;
    logic [2:0]             sync_q;
    logic [WINDOW_LOG2-1:0] win_cnt_q;
    logic [WINDOW_LOG2-1:0] acc_q;
    logic [WINDOW_LOG2-1:0] win_sum_d;
    logic                   rise;
    logic                   win_end;

    // sync_q[0..2] = ff1..ff3; the edge seen on the last window cycle is folded into that window.
    always_comb begin
        rise      = sync_q[1] & ~sync_q[2];
        win_end   = &win_cnt_q;
        win_sum_d = acc_q + WINDOW_LOG2'(rise);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            win_cnt_q  <= '0;
            acc_q      <= '0;
            edge_count <= '0;
            alt_ok     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], mon_clk};
            win_cnt_q <= win_cnt_q + WINDOW_LOG2'(1);
            if (win_end) begin
                edge_count <= win_sum_d;
                alt_ok     <= (win_sum_d >= MIN_EDGES_W);
                acc_q      <= '0;
            end else begin
                acc_q <= win_sum_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PRIMARY;
            hold_q    <= '0;
            sel       <= 1'b0;
            switching <= 1'b0;
            fail      <= 1'b0;
        end else begin
            fail <= 1'b0;
            case (state_q)
                PRIMARY: begin
                    if (req_alt && alt_ok) begin
                        state_q   <= TO_ALT;
                        sel       <= 1'b1;
                        switching <= 1'b1;
                        hold_q    <= HOLD_LOAD;
                    end
                end
                TO_ALT: begin
                    if (hold_q == '0) begin
                        state_q   <= ALT;
                        switching <= 1'b0;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                ALT: begin
                    // With req_alt still high, the only way out is a lost clock.
                    if (!req_alt || (AUTO_REVERT && !alt_ok)) begin
                        state_q   <= TO_PRI;
                        sel       <= 1'b0;
                        switching <= 1'b1;
                        hold_q    <= HOLD_LOAD;
                        fail      <= AUTO_REVERT && req_alt;
                    end
                end
                TO_PRI: begin
                    if (hold_q == '0) begin
                        state_q   <= PRIMARY;
                        switching <= 1'b0;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: state_q <= PRIMARY;
            endcase
        end
    end

    assign state_dbg = state_q;

endmodule
